// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
// Digit count helper sizes the scratch BCD register from the binary width.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH  = 4'd5;
  localparam logic [3:0] ADJ_ADD     = 4'd3;

  // Decimal digits needed for a data_w-bit unsigned value (log10(2) ~ 0.30103).
  function automatic int int_digits(input int data_w);
    return (data_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_converter_if.sv
// Start/done bus between the converter and its requester (master) / engine (slave).
// start is only honoured while the engine is idle; results hold between done pulses.
interface bin_to_bcd_converter_if #(
  parameter int DATA_W     = 32,
  parameter int OUT_DIGITS = 8
);
  import bcd_pkg::*;

  logic                              start;
  logic [DATA_W-1:0]                 bin_in;
  logic                              busy;
  logic                              done;
  logic [BCD_DIGIT_W*OUT_DIGITS-1:0] bcd_out;
  logic                              overflow;
  logic                              negative;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, overflow, negative
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, overflow, negative
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD nibble of 5 or more, zero latency.
// Inputs never exceed 9, so the result always fits in 4 bits.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_nibble,
  output logic [BCD_DIGIT_W-1:0] o_nibble
);

  assign o_nibble = (i_nibble >= ADJ_THRESH) ? i_nibble + ADJ_ADD : i_nibble;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential shift-and-add-3 converter: one bit per clock, done DATA_W+1 edges after start.
// start ignored while busy; outputs hold until next done. BIN_TO_BCD_SIGNED_EN: two's complement input.
module bin_to_bcd_converter
  import bcd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OUT_DIGITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  bin_to_bcd_converter_if.slave bus
);

  localparam int INT_DIGITS  = int_digits(DATA_W);
  localparam int SCR_W       = BCD_DIGIT_W * INT_DIGITS;
  localparam int OUT_W       = BCD_DIGIT_W * OUT_DIGITS;
  localparam int FULL_DIGITS = (INT_DIGITS > OUT_DIGITS) ? INT_DIGITS : OUT_DIGITS;
  localparam int FULL_W      = BCD_DIGIT_W * FULL_DIGITS;
  localparam int CNT_W       = $clog2(DATA_W + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SCR_W-1:0]  r_bcd;
  logic [SCR_W-1:0]  w_bcd_adj;
  logic [DATA_W-1:0] r_bin;
  logic [DATA_W-1:0] w_mag;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_cap;
  logic              w_sign;
  logic              r_busy;
  logic              r_done;
  logic [OUT_W-1:0]  r_bcd_out;
  logic              r_ovf;
  logic              r_neg;
  logic [FULL_W-1:0] w_full;
  logic              w_ovf;
  logic              w_last_iter;

`ifdef BIN_TO_BCD_SIGNED_EN
  // Magnitude taken as unsigned so the most negative value converts correctly.
  assign w_sign = bus.bin_in[DATA_W-1];
  assign w_mag  = w_sign ? -bus.bin_in : bus.bin_in;
`else
  assign w_sign = 1'b0;
  assign w_mag  = bus.bin_in;
`endif

  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_nibble (r_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_nibble (w_bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_full = FULL_W'(r_bcd);

  if (INT_DIGITS > OUT_DIGITS) begin : g_ovf
    assign w_ovf = |w_full[FULL_W-1:OUT_W];
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  assign w_last_iter = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last_iter) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_neg_cap <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
      r_ovf     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin     <= w_mag;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_neg_cap <= w_sign;
            r_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_bcd_out <= w_full[OUT_W-1:0];
          r_ovf     <= w_ovf;
          r_neg     <= r_neg_cap;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd_out;
  assign bus.overflow = r_ovf;
  assign bus.negative = r_neg;

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: driver queues expected results, monitor checks them on done.
module tb_bin_to_bcd_converter;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic        neg;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;
  logic [31:0] last_bcd = '0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_converter_if #(.DATA_W(32), .OUT_DIGITS(8)) bus ();

  bin_to_bcd_converter #(.DATA_W(32), .OUT_DIGITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_one_cycle", 64'(bus.done), 64'd0);
      if (bus.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("bcd_out",  64'(bus.bcd_out),  64'(mon_e.bcd));
          chk("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
          chk("negative", 64'(bus.negative), 64'(mon_e.neg));
          chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      prev_done = bus.done;
    end
  end

  // Called just after a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [31:0] v, input logic [31:0] eb, input logic eo, input logic en);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    e.neg = en;
    e.cyc = cyc + 34;
    sb_q.push_back(e);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = '0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int busy_n = 0;
    bit held = 1'b1;
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.bcd_out !== last_bcd) held = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({tag, "_output_held"}, 64'(held), 64'd1);
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] eb,
                         input logic eo, input logic en);
    issue(v, eb, eo, en);
    wait_done(tag, 33);
    last_bcd = eb;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",     64'(bus.busy),     64'd0);
    chk("rst_done",     64'(bus.done),     64'd0);
    chk("rst_bcd_out",  64'(bus.bcd_out),  64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_negative", 64'(bus.negative), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    convert("zero",     32'd0,          32'h0000_0000, 1'b0, 1'b0);
    convert("12345678", 32'h00BC_614E,  32'h1234_5678, 1'b0, 1'b0);
    convert("99999999", 32'd99999999,   32'h9999_9999, 1'b0, 1'b0);
    convert("1e8",      32'd100000000,  32'h0000_0000, 1'b1, 1'b0);
    convert("nine",     32'd9,          32'h0000_0009, 1'b0, 1'b0);
    convert("ten",      32'd10,         32'h0000_0010, 1'b0, 1'b0);
`ifdef BIN_TO_BCD_SIGNED_EN
    convert("all_ones", 32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 1'b1);
    convert("min_neg",  32'h8000_0000,  32'h4748_3648, 1'b1, 1'b1);
`else
    convert("all_ones", 32'hFFFF_FFFF,  32'h9496_7295, 1'b1, 1'b0);
    convert("msb_only", 32'h8000_0000,  32'h4748_3648, 1'b1, 1'b0);
`endif

    // Second start while busy must be ignored.
    issue(32'd42, 32'h0000_0042, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 32'd7;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = '0;
    wait_done("ignored_start", 24);
    last_bcd = 32'h0000_0042;

    // Start in the cycle right after done.
    convert("back_to_back", 32'd1234, 32'h0000_1234, 1'b0, 1'b0);

    // Reset in the middle of a conversion abandons it.
    issue(32'd5678, 32'h0000_5678, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_busy",     64'(bus.busy),     64'd0);
    chk("midrst_done",     64'(bus.done),     64'd0);
    chk("midrst_bcd_out",  64'(bus.bcd_out),  64'd0);
    chk("midrst_overflow", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    last_bcd = '0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'(dc));

    convert("after_rst_255", 32'd255, 32'h0000_0255, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
